// File: rtl/jtag_debug_scan_master_if.sv
// Command/response and virtual-JTAG signal bundle for the debug scan master.
// master: the scan initiator. slave: the bench or target side.
interface jtag_debug_scan_master_if #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_data;
    logic                rsp_valid;
    logic [DR_WIDTH-1:0] rsp_data;
    logic [IR_WIDTH-1:0] rsp_ir_out;
    logic                vji_tck;
    logic                vji_tdi;
    logic [IR_WIDTH-1:0] vji_ir_in;
    logic                vji_uir;
    logic                vji_cdr;
    logic                vji_sdr;
    logic                vji_udr;
    logic                vji_rti;
    logic                vji_tdo;
    logic [IR_WIDTH-1:0] vji_ir_out;

    modport master (
        input  cmd_valid, cmd_ir, cmd_data, vji_tdo, vji_ir_out,
        output cmd_ready, rsp_valid, rsp_data, rsp_ir_out,
               vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
    );

    modport slave (
        output cmd_valid, cmd_ir, cmd_data, vji_tdo, vji_ir_out,
        input  cmd_ready, rsp_valid, rsp_data, rsp_ir_out,
               vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
    );
endinterface

// File: rtl/jtag_debug_scan_master.sv
// Virtual-JTAG scan initiator: one IR-select (UIR) plus CDR/SDR/UDR data scan
// per command. tck is a registered, clk-divided clock; all state changes land
// on the tck falling edge (phase wrap), tdo/ir_out are sampled on the rising edge.
module jtag_debug_scan_master #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    jtag_debug_scan_master_if.master dbg_io
);
    localparam int PW = $clog2(2 * TCK_DIV);
    localparam int BW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
    localparam logic [PW-1:0] PH_LAST  = PW'(2 * TCK_DIV - 1);
    localparam logic [PW-1:0] PH_RISE  = PW'(TCK_DIV);
    localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_DONE} state_e;

    state_e              state_q;
    logic [PW-1:0]       phase_q, phase_d;
    logic [BW-1:0]       bit_q;
    logic                wrap, rise;
    logic                tck_q, tdi_q, uir_q, cdr_q, sdr_q, udr_q, rti_q;
    logic                ready_q, rsp_valid_q;
    logic [IR_WIDTH-1:0] ir_in_q, ir_cap_q, rsp_ir_q;
    logic [DR_WIDTH-1:0] data_q, capture_q, rsp_data_q;

    // Phase counter next value plus tck edge markers derived from it.
    always_comb begin
        wrap    = (phase_q == PH_LAST);
        phase_d = wrap ? '0 : phase_q + 1'b1;
        rise    = (phase_d == PH_RISE);
    end

    // Scan sequencer; every interface output is a register written here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            bit_q       <= '0;
            tck_q       <= 1'b0;
            tdi_q       <= 1'b0;
            uir_q       <= 1'b0;
            cdr_q       <= 1'b0;
            sdr_q       <= 1'b0;
            udr_q       <= 1'b0;
            rti_q       <= 1'b1;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            ir_in_q     <= '0;
            ir_cap_q    <= '0;
            rsp_ir_q    <= '0;
            data_q      <= '0;
            capture_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (dbg_io.cmd_valid && ready_q) begin
                        data_q  <= dbg_io.cmd_data;
                        ir_in_q <= dbg_io.cmd_ir;
                        ready_q <= 1'b0;
                        rti_q   <= 1'b0;
                        uir_q   <= 1'b1;
                        phase_q <= '0;
                        bit_q   <= '0;
                        state_q <= S_UIR;
                    end
                end
                S_UIR, S_CDR, S_SDR, S_UDR: begin
                    phase_q <= phase_d;
                    tck_q   <= (phase_d >= PH_RISE);
                    // Target data is sampled as tck goes high.
                    if (rise && state_q == S_CDR) ir_cap_q <= dbg_io.vji_ir_out;
                    if (rise && state_q == S_SDR) capture_q[bit_q] <= dbg_io.vji_tdo;
                    if (wrap) begin
                        case (state_q)
                            S_UIR: begin
                                uir_q   <= 1'b0;
                                cdr_q   <= 1'b1;
                                state_q <= S_CDR;
                            end
                            S_CDR: begin
                                cdr_q   <= 1'b0;
                                sdr_q   <= 1'b1;
                                bit_q   <= '0;
                                tdi_q   <= data_q[0];
                                state_q <= S_SDR;
                            end
                            S_SDR: begin
                                if (bit_q == BIT_LAST) begin
                                    sdr_q   <= 1'b0;
                                    udr_q   <= 1'b1;
                                    tdi_q   <= 1'b0;
                                    state_q <= S_UDR;
                                end else begin
                                    bit_q <= bit_q + 1'b1;
                                    tdi_q <= data_q[bit_q + 1'b1];
                                end
                            end
                            default: begin
                                // Leaving UDR: publish the response during DONE.
                                udr_q       <= 1'b0;
                                ir_in_q     <= '0;
                                rsp_valid_q <= 1'b1;
                                rsp_data_q  <= capture_q;
                                rsp_ir_q    <= ir_cap_q;
                                state_q     <= S_DONE;
                            end
                        endcase
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    rti_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign dbg_io.cmd_ready  = ready_q;
    assign dbg_io.rsp_valid  = rsp_valid_q;
    assign dbg_io.rsp_data   = rsp_data_q;
    assign dbg_io.rsp_ir_out = rsp_ir_q;
    assign dbg_io.vji_tck    = tck_q;
    assign dbg_io.vji_tdi    = tdi_q;
    assign dbg_io.vji_ir_in  = ir_in_q;
    assign dbg_io.vji_uir    = uir_q;
    assign dbg_io.vji_cdr    = cdr_q;
    assign dbg_io.vji_sdr    = sdr_q;
    assign dbg_io.vji_udr    = udr_q;
    assign dbg_io.vji_rti    = rti_q;
endmodule
